// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DATA_W = 32;

  // Addresses at or above this are memory-mapped IO (UART).
  localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Controller states: idle/arbitrating, byte-serial read, byte-serial write.
  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  // LSB access-length encodings.
  localparam logic [1:0] LEN_1B = 2'b00;
  localparam logic [1:0] LEN_2B = 2'b01;
  localparam logic [1:0] LEN_4B = 2'b11;

  // Number of byte beats for an LSB length code; the unused code 2'b10 maps to 4.
  function automatic logic [2:0] len_to_beats(input logic [1:0] len);
    case (len)
      LEN_1B:  return 3'd1;
      LEN_2B:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM/IO port between instruction fetch and
// the load/store buffer. Each request is serialised into byte beats; read bytes
// are reassembled into a 32-bit little-endian word.
//
// Request handshake: a requester raises *_valid with stable request fields and
// holds them until its *_done pulse (one cycle, registered). A request is taken
// only at an IDLE edge with rollback low and both done outputs low, so every
// done is followed by at least one idle bubble cycle. Requests seen while busy
// simply wait; nothing is queued here.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              rollback,
  input  logic              if_to_mc_valid,
  input  logic [ADDR_W-1:0] if_to_mc_addr,
  output logic              mc_to_if_done,
  output logic [INST_W-1:0] mc_to_if_inst,
  input  logic              lsb_to_mc_valid,
  input  logic              lsb_to_mc_wr,
  input  logic [1:0]        lsb_to_mc_len,
  input  logic [ADDR_W-1:0] lsb_to_mc_addr,
  input  logic [DATA_W-1:0] lsb_to_mc_data,
  output logic              mc_to_lsb_done,
  output logic [DATA_W-1:0] mc_to_lsb_data,
  output mc_state_e         dbg_state
);

  mc_state_e         r_state;
  logic [2:0]        r_cnt;        // current beat index (read: also capture lane + 1)
  logic [2:0]        r_beats;      // beats in the active request
  logic [ADDR_W-1:0] r_addr;       // request base address
  logic [DATA_W-1:0] r_data;       // store data
  logic [DATA_W-1:0] r_asm;        // read assembly register, shared by both requesters
  logic              r_owner_lsb;  // active request belongs to LSB
  logic              r_last_lsb;   // last grant went to LSB
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_if_done;
  logic              r_lsb_done;
  logic [INST_W-1:0] r_if_inst;
  logic [DATA_W-1:0] r_lsb_data;

  logic              w_accept;
  logic              w_grant_lsb;
  logic [ADDR_W-1:0] w_req_addr;
  logic [2:0]        w_req_beats;
  logic              w_req_wr;
  logic              w_io_stall;
  logic [2:0]        w_next_idx;
  logic [ADDR_W-1:0] w_next_addr;
  logic [7:0]        w_next_byte;
  logic [1:0]        w_lane;
  logic [DATA_W-1:0] w_asm_next;

  // Round-robin: on contention the requester that did not win last time goes.
  assign w_grant_lsb = lsb_to_mc_valid && (!if_to_mc_valid || !r_last_lsb);
  assign w_accept    = !rollback && !r_if_done && !r_lsb_done &&
                       (if_to_mc_valid || lsb_to_mc_valid);
  assign w_req_addr  = w_grant_lsb ? lsb_to_mc_addr : if_to_mc_addr;
  assign w_req_beats = w_grant_lsb ? len_to_beats(lsb_to_mc_len) : 3'd4;
  assign w_req_wr    = w_grant_lsb && lsb_to_mc_wr;

  assign w_io_stall  = (r_addr >= IO_BASE) && io_buffer_full;
  assign w_next_idx  = r_cnt + 3'd1;
  assign w_next_addr = r_addr + {29'd0, w_next_idx};   // wraps modulo 2^32
  assign w_next_byte = r_data[{w_next_idx[1:0], 3'b000} +: 8];
  // Byte presented on mem_din now was addressed one beat earlier.
  assign w_lane      = r_cnt[1:0] - 2'd1;

  // Merge the incoming read byte into its lane of the assembly word.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{w_lane, 3'b000} +: 8] = mem_din;
  end

  // Controller FSM: arbitration, beat sequencing, capture and done generation.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= MC_IDLE;
      r_cnt       <= 3'd0;
      r_beats     <= 3'd0;
      r_addr      <= '0;
      r_data      <= '0;
      r_asm       <= '0;
      r_owner_lsb <= 1'b0;
      r_last_lsb  <= 1'b0;
      r_mem_a     <= '0;
      r_mem_dout  <= '0;
      r_if_done   <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_inst   <= '0;
      r_lsb_data  <= '0;
    end else if (rdy_in) begin
      case (r_state)
        MC_IDLE: begin
          r_if_done  <= 1'b0;
          r_lsb_done <= 1'b0;
          if (w_accept) begin
            r_owner_lsb <= w_grant_lsb;
            r_last_lsb  <= w_grant_lsb;
            r_addr      <= w_req_addr;
            r_mem_a     <= w_req_addr;
            r_beats     <= w_req_beats;
            r_cnt       <= 3'd0;
            r_asm       <= '0;
            if (w_req_wr) begin
              r_data     <= lsb_to_mc_data;
              r_mem_dout <= lsb_to_mc_data[7:0];
              r_state    <= MC_WRITE;
            end else begin
              r_state    <= MC_READ;
            end
          end
        end
        MC_READ: begin
          // A flush kills speculative reads outright, even on the final capture.
          if (rollback) begin
            r_state <= MC_IDLE;
          end else begin
            if (r_cnt != 3'd0) r_asm <= w_asm_next;
            if (r_cnt == r_beats) begin
              r_state <= MC_IDLE;
              if (r_owner_lsb) begin
                r_lsb_done <= 1'b1;
                r_lsb_data <= w_asm_next;
              end else begin
                r_if_done <= 1'b1;
                r_if_inst <= w_asm_next;
              end
            end else begin
              r_cnt <= w_next_idx;
              if (w_next_idx != r_beats) r_mem_a <= w_next_addr;
            end
          end
        end
        MC_WRITE: begin
          // Committed stores ignore rollback; IO back-pressure freezes the beat.
          if (!w_io_stall) begin
            if (w_next_idx == r_beats) begin
              r_state    <= MC_IDLE;
              r_lsb_done <= 1'b1;
            end else begin
              r_cnt      <= w_next_idx;
              r_mem_a    <= w_next_addr;
              r_mem_dout <= w_next_byte;
            end
          end
        end
        default: r_state <= MC_IDLE;
      endcase
    end
  end

  assign mem_wr         = (r_state == MC_WRITE) && rdy_in && !w_io_stall;
  assign mem_a          = r_mem_a;
  assign mem_dout       = r_mem_dout;
  assign mc_to_if_done  = r_if_done;
  assign mc_to_if_inst  = r_if_inst;
  assign mc_to_lsb_done = r_lsb_done;
  assign mc_to_lsb_data = r_lsb_data;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios plus randomized traffic,
// with a byte-addressed reference memory and expected-response queues.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_full = 1'b0;
  logic        rollback = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        lsb_valid = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [1:0]  lsb_len = 2'b00;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_data = '0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  mc_state_e   dbg_state;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_full), .rollback(rollback),
    .if_to_mc_valid(if_valid), .if_to_mc_addr(if_addr),
    .mc_to_if_done(if_done), .mc_to_if_inst(if_inst),
    .lsb_to_mc_valid(lsb_valid), .lsb_to_mc_wr(lsb_wr), .lsb_to_mc_len(lsb_len),
    .lsb_to_mc_addr(lsb_addr), .lsb_to_mc_data(lsb_data),
    .mc_to_lsb_done(lsb_done), .mc_to_lsb_data(lsb_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] if_exp_q[$];
  logic [32:0] lsb_exp_q[$];   // {is_store, load data}
  logic [39:0] wr_exp_q[$];    // {addr, byte}
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] ma_log [40];
  logic        wr_log [40];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Byte RAM with one-cycle read latency; frozen together with the core by rdy.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : init_byte(mem_a);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_addr  = a;
    if_valid = 1'b1;
    if_exp_q.push_back({ref_rd(a + 32'd3), ref_rd(a + 32'd2), ref_rd(a + 32'd1), ref_rd(a)});
  endtask

  task automatic issue_lsb(input logic wr, input logic [1:0] len, input logic [31:0] a,
                           input logic [31:0] d);
    int n;
    logic [31:0] v;
    logic [31:0] ai;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    lsb_wr = wr; lsb_len = len; lsb_addr = a; lsb_data = d; lsb_valid = 1'b1;
    v = '0;
    for (int i = 0; i < n; i++) begin
      ai = a + i;
      if (wr) begin
        ref_mem[ai] = d[8*i +: 8];
        wr_exp_q.push_back({ai, d[8*i +: 8]});
      end else begin
        v[8*i +: 8] = ref_rd(ai);
      end
    end
    lsb_exp_q.push_back({wr, wr ? 32'd0 : v});
  endtask

  // One isolated request; reports cycles from issue to the consumed done (-1: none).
  task automatic do_single(input logic is_lsb, input logic wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int io_until, input int rdy_at, input int rdy_n,
                           input int rb_at, output int lat);
    lat = -1;
    if (is_lsb) issue_lsb(wr, len, addr, data);
    else        issue_if(addr);
    for (int k = 0; k < 40; k++) begin
      io_full  = (k < io_until);
      rdy      = !(k >= rdy_at && k < rdy_at + rdy_n);
      rollback = (k == rb_at);
      if (k == rb_at && !(is_lsb && wr)) begin
        if (is_lsb) begin lsb_valid = 1'b0; void'(lsb_exp_q.pop_back()); end
        else        begin if_valid  = 1'b0; void'(if_exp_q.pop_back());  end
      end
      #1;
      ma_log[k] = mem_a;
      wr_log[k] = mem_wr;
      if (k > 0 && rdy && (is_lsb ? lsb_done : if_done)) begin
        lat = k;
        break;
      end
      if (rb_at >= 0 && k > rb_at + 10) break;
      @(posedge clk); #1;
    end
    if_valid = 1'b0; lsb_valid = 1'b0;
    io_full = 1'b0; rdy = 1'b1; rollback = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [32:0] le;
    logic [39:0] we;
    if (!rst) begin
      if (!rdy) begin
        check("wr_while_frozen", 64'(mem_wr), 64'd0);
      end else begin
        if (mem_wr) begin
          if (wr_exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_wr_beat actual=%0h expected=none", {mem_a, mem_dout});
          end else begin
            we = wr_exp_q.pop_front();
            check("wr_beat", 64'({mem_a, mem_dout}), 64'(we));
          end
        end
        if (if_done) begin
          if (if_exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_if_done actual=1 expected=0");
          end else begin
            check("if_inst", 64'(if_inst), 64'(if_exp_q.pop_front()));
          end
        end
        if (lsb_done) begin
          if (lsb_exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_lsb_done actual=1 expected=0");
          end else begin
            le = lsb_exp_q.pop_front();
            if (!le[32]) check("lsb_load_data", 64'(lsb_rdata), 64'(le[31:0]));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int done_cyc[$];
    logic done_who[$];
    logic if_busy, lsb_busy, lsb_busy_wr;
    logic [1:0] lens [3];
    lens[0] = 2'b00; lens[1] = 2'b01; lens[2] = 2'b11;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_a", 64'(mem_a), 64'd0);
    check("rst_mem_dout", 64'(mem_dout), 64'd0);
    check("rst_if_done", 64'(if_done), 64'd0);
    check("rst_lsb_done", 64'(lsb_done), 64'd0);
    check("rst_if_inst", 64'(if_inst), 64'd0);
    check("rst_lsb_data", 64'(lsb_rdata), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(MC_IDLE));
    #1 rst = 1'b0;

    // Contention from reset: LSB first, IF after the bubble, then alternate.
    @(posedge clk); #1;
    issue_lsb(1'b0, 2'b00, 32'h210, 32'd0);
    issue_if(32'h1040);
    for (int k = 0; k < 60 && done_cyc.size() < 4; k++) begin
      if (k > 0 && lsb_done) begin
        done_cyc.push_back(k); done_who.push_back(1'b1);
        if (done_cyc.size() < 4) issue_lsb(1'b0, 2'b00, 32'h211 + k, 32'd0);
      end
      if (k > 0 && if_done) begin
        done_cyc.push_back(k); done_who.push_back(1'b0);
        if (done_cyc.size() < 4) issue_if(32'h1080 + 4 * k);
      end
      if (done_cyc.size() < 4) begin @(posedge clk); #1; end
    end
    check("arb_done_count", 64'(done_cyc.size()), 64'd4);
    if (done_cyc.size() == 4) begin
      check("arb_who0", 64'(done_who[0]), 64'd1);
      check("arb_who1", 64'(done_who[1]), 64'd0);
      check("arb_who2", 64'(done_who[2]), 64'd1);
      check("arb_who3", 64'(done_who[3]), 64'd0);
      check("arb_cyc0", 64'(done_cyc[0]), 64'd3);
      check("arb_cyc1", 64'(done_cyc[1]), 64'd10);
      check("arb_cyc2", 64'(done_cyc[2]), 64'd14);
      check("arb_cyc3", 64'(done_cyc[3]), 64'd21);
    end
    if_valid = 1'b0;
    if (lsb_valid) begin lsb_valid = 1'b0; void'(lsb_exp_q.pop_back()); end

    // IF fetch 0x1000 -> 0x00000513, beats in cycles 1-4, done after edge 5
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    @(posedge clk); #1;
    do_single(1'b0, 1'b0, 2'b00, 32'h1000, 32'd0, 0, -1, 0, -1, lat);
    check("fetch_latency", 64'(lat), 64'd6);
    for (int i = 0; i < 4; i++) check("fetch_mem_a", 64'(ma_log[i+1]), 64'(32'h1000 + i));
    check("fetch_inst", 64'(if_inst), 64'h0000_0513);

    // 2-byte store 0xBEEF at 0x200
    @(posedge clk); #1;
    do_single(1'b1, 1'b1, 2'b01, 32'h200, 32'h0000_BEEF, 0, -1, 0, -1, lat);
    check("st2_latency", 64'(lat), 64'd3);
    check("st2_a0", 64'({ma_log[1], wr_log[1]}), 64'({32'h200, 1'b1}));
    check("st2_a1", 64'({ma_log[2], wr_log[2]}), 64'({32'h201, 1'b1}));

    // IO store stalled 3 cycles by a full UART buffer
    @(posedge clk); #1;
    do_single(1'b1, 1'b1, 2'b00, 32'h0003_0000, 32'h41, 4, -1, 0, -1, lat);
    check("io_latency", 64'(lat), 64'd5);
    for (int i = 1; i <= 3; i++) check("io_stall_wr", 64'(wr_log[i]), 64'd0);
    check("io_beat_wr", 64'(wr_log[4]), 64'd1);

    // Rollback during IF beat 2 aborts; a new fetch is served normally
    @(posedge clk); #1;
    do_single(1'b0, 1'b0, 2'b00, 32'h1100, 32'd0, 0, -1, 0, 3, lat);
    check("rb_fetch_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    check("rb_state_idle", 64'(dbg_state), 64'(MC_IDLE));
    @(posedge clk); #1;
    do_single(1'b0, 1'b0, 2'b00, 32'h2000, 32'd0, 0, -1, 0, -1, lat);
    check("refetch_latency", 64'(lat), 64'd6);

    // Rollback during a 4-byte store is ignored
    @(posedge clk); #1;
    do_single(1'b1, 1'b1, 2'b11, 32'h300, 32'hDEAD_BEEF, 0, -1, 0, 2, lat);
    check("rb_store_latency", 64'(lat), 64'd5);

    // rdy low for 2 cycles mid-read stretches latency by 2
    @(posedge clk); #1;
    do_single(1'b0, 1'b0, 2'b00, 32'h1010, 32'd0, 0, 3, 2, -1, lat);
    check("rdy_latency", 64'(lat), 64'd8);

    // 4-byte load across the top of the address space wraps to 0
    @(posedge clk); #1;
    do_single(1'b1, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'd0, 0, -1, 0, -1, lat);
    check("wrap_latency", 64'(lat), 64'd6);
    check("wrap_a2", 64'(ma_log[3]), 64'd0);
    check("wrap_a3", 64'(ma_log[4]), 64'd1);

    // Asynchronous reset in the middle of a fetch
    @(posedge clk); #1;
    issue_if(32'h1020);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_a", 64'(mem_a), 64'd0);
    check("arst_if_inst", 64'(if_inst), 64'd0);
    check("arst_lsb_data", 64'(lsb_rdata), 64'd0);
    check("arst_state", 64'(dbg_state), 64'(MC_IDLE));
    if_valid = 1'b0;
    void'(if_exp_q.pop_back());
    @(posedge clk); #2 rst = 1'b0;

    // Randomized mixed traffic
    if_busy = 1'b0; lsb_busy = 1'b0; lsb_busy_wr = 1'b0;
    repeat (2500) begin
      @(posedge clk); #1;
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = 1'b0;
      io_full  = ($urandom_range(0, 3) == 0);
      if (rdy && if_busy && if_done)   begin if_busy = 1'b0;  if_valid = 1'b0;  end
      if (rdy && lsb_busy && lsb_done) begin lsb_busy = 1'b0; lsb_valid = 1'b0; end
      if (rdy && $urandom_range(0, 24) == 0) begin
        rollback = 1'b1;
        if (if_busy) begin if_busy = 1'b0; if_valid = 1'b0; void'(if_exp_q.pop_back()); end
        if (lsb_busy && !lsb_busy_wr) begin
          lsb_busy = 1'b0; lsb_valid = 1'b0; void'(lsb_exp_q.pop_back());
        end
      end else begin
        if (!if_busy && $urandom_range(0, 2) == 0) begin
          issue_if(32'h1000 + ($urandom_range(0, 255) << 2));
          if_busy = 1'b1;
        end
        if (!lsb_busy && $urandom_range(0, 2) == 0) begin
          lsb_busy_wr = 1'($urandom_range(0, 1));
          if (lsb_busy_wr)
            issue_lsb(1'b1, lens[$urandom_range(0, 2)],
                      ($urandom_range(0, 3) == 0) ? 32'h0003_0000 + $urandom_range(0, 15)
                                                  : 32'h200 + $urandom_range(0, 255),
                      $urandom);
          else
            issue_lsb(1'b0, lens[$urandom_range(0, 2)],
                      ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFD + $urandom_range(0, 2)
                                                   : 32'h200 + $urandom_range(0, 255),
                      32'd0);
          lsb_busy = 1'b1;
        end
      end
    end

    // Drain outstanding requests
    rollback = 1'b0; io_full = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 300 && (if_busy || lsb_busy); k++) begin
      @(posedge clk); #1;
      if (if_busy && if_done)   begin if_busy = 1'b0;  if_valid = 1'b0;  end
      if (lsb_busy && lsb_done) begin lsb_busy = 1'b0; lsb_valid = 1'b0; end
    end
    check("drain_idle", 64'({if_busy, lsb_busy}), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("if_q_empty", 64'(if_exp_q.size()), 64'd0);
    check("lsb_q_empty", 64'(lsb_exp_q.size()), 64'd0);
    check("wr_q_empty", 64'(wr_exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
